// File: rtl/ad5628_pkg.sv
// Shared AD5628 scheduler types: FSM states, DAC command codes and the frame packer.
// Frame layout: [31:28]=0, [27:24]=cmd, [23:20]={0,ch}, [19:8]=code, [7:0]=0.
package ad5628_pkg;

    typedef enum logic [2:0] {
        INIT_SEND,
        INIT_WAIT,
        IDLE,
        SEND,
        WAIT_DONE
    } state_t;

    localparam int CH_W    = 3;
    localparam int CODE_W  = 12;
    localparam int FRAME_W = 32;

    localparam logic [3:0] CMD_WRUPD  = 4'h3;
    localparam logic [3:0] CMD_INTREF = 4'h8;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [3:0]        cmd,
        input logic [CH_W-1:0]   ch,
        input logic [CODE_W-1:0] code
    );
        return {4'h0, cmd, 1'b0, ch, code, 8'h00};
    endfunction

endpackage

// File: rtl/ad5628_rr_arb.sv
// Round-robin channel picker: combinational select starting one past the last grant.
// Zero-cycle select; the last-grant pointer only advances when grant_en accepts a grant.
module ad5628_rr_arb #(
    parameter int NUM_CH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              grant_en,
    output logic [NUM_CH-1:0] grant,
    output logic [2:0]        grant_idx,
    output logic              grant_vld
);
    import ad5628_pkg::*;

    logic [CH_W-1:0] last_ptr;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            sum = {1'b0, last_ptr} + (CH_W+1)'(k);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            cand = sum[CH_W-1:0];
            if (!grant_vld && req[cand]) begin
                grant_vld   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Reset to the highest index so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ptr <= CH_W'(NUM_CH - 1);
        end else if (grant_en && grant_vld) begin
            last_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/ad5628_ch_sched.sv
// AD5628 write scheduler: coalesces per-channel codes, sends init frame, then RR write-and-update frames.
// Write to frm_valid in 2 cycles; frame held until frm_ready, next launch only after frm_done.
module ad5628_ch_sched #(
    parameter int          NUM_CH    = 8,
    parameter int          DATA_W    = 12,
    parameter logic [31:0] INIT_WORD = 32'h0800_0001,
    parameter logic [3:0]  CMD_WRUPD = 4'h3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_wr_en,
    input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
    output logic [NUM_CH-1:0]        ch_pending,
    output logic                     frm_valid,
    output logic [31:0]              frm_data,
    input  logic                     frm_ready,
    input  logic                     frm_done,
    output logic                     init_done,
    output logic                     busy,
    output logic [2:0]               cur_ch
);
    import ad5628_pkg::*;

    state_t            state;
    logic [DATA_W-1:0] code_reg [NUM_CH];
    logic [NUM_CH-1:0] grant;
    logic [2:0]        grant_idx;
    logic              grant_vld;
    logic              grant_en;
    logic              launch;

    assign grant_en = (state == IDLE);
    assign launch   = grant_en && grant_vld;

    ad5628_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (ch_pending),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // A write landing on the launching channel wins: the frame takes the old
    // code and the pending bit survives with the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_pending <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                code_reg[i] <= '0;
            end
        end else begin
            ch_pending <= (ch_pending & ~(grant & {NUM_CH{launch}})) | ch_wr_en;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_wr_en[i]) begin
                    code_reg[i] <= ch_wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_SEND;
            frm_valid <= 1'b0;
            frm_data  <= '0;
            init_done <= 1'b0;
            busy      <= 1'b0;
            cur_ch    <= '0;
        end else begin
            case (state)
                INIT_SEND: begin
                    busy <= 1'b1;
                    if (frm_valid && frm_ready) begin
                        frm_valid <= 1'b0;
                        if (frm_done) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= INIT_WAIT;
                        end
                    end else begin
                        frm_valid <= 1'b1;
                        frm_data  <= INIT_WORD;
                    end
                end
                INIT_WAIT: begin
                    if (frm_done) begin
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    if (grant_vld) begin
                        frm_valid <= 1'b1;
                        frm_data  <= pack_frame(CMD_WRUPD, grant_idx, code_reg[grant_idx]);
                        cur_ch    <= grant_idx;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (frm_ready) begin
                        frm_valid <= 1'b0;
                        if (frm_done) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (frm_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    frm_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= INIT_SEND;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad5628_ch_sched.sv
// Bench for ad5628_ch_sched: directed writes, queued expected frames, negedge monitor
// that also models the serializer (accept, then frm_done a fixed number of cycles later).
module tb_ad5628_ch_sched;
    localparam int NUM_CH   = 8;
    localparam int DATA_W   = 12;
    localparam int DONE_DLY = 5;

    typedef struct {
        logic [31:0] frame;
        logic [2:0]  ch;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH-1:0]        ch_wr_en = '0;
    logic [NUM_CH*DATA_W-1:0] ch_wr_data = '0;
    logic [NUM_CH-1:0]        ch_pending;
    logic                     frm_valid;
    logic [31:0]              frm_data;
    logic                     frm_ready = 1'b1;
    logic                     frm_done = 1'b0;
    logic                     init_done;
    logic                     busy;
    logic [2:0]               cur_ch;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks  = 0;
    int          errors  = 0;
    int          accepts = 0;
    int          cd      = 0;
    int          acc_before;
    logic [11:0] codes [NUM_CH];

    always #5 clk = ~clk;

    ad5628_ch_sched dut (
        .clk        (clk),
        .rst        (rst),
        .ch_wr_en   (ch_wr_en),
        .ch_wr_data (ch_wr_data),
        .ch_pending (ch_pending),
        .frm_valid  (frm_valid),
        .frm_data   (frm_data),
        .frm_ready  (frm_ready),
        .frm_done   (frm_done),
        .init_done  (init_done),
        .busy       (busy),
        .cur_ch     (cur_ch)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] f, input logic [2:0] c);
        exp_t e;
        e.frame = f;
        e.ch    = c;
        exp_q.push_back(e);
    endtask

    task automatic post(input logic [NUM_CH-1:0] mask);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr_data[i*DATA_W +: DATA_W] = codes[i];
        end
        ch_wr_en = mask;
        tick();
        ch_wr_en = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(!busy && ch_pending == '0 && !frm_valid && exp_q.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s: timeout busy=%b pending=%h queued=%0d required idle", name, busy, ch_pending, exp_q.size());
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!init_done && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s: init_done got 0 expected 1 within 100 cycles", name);
        end
    endtask

    // Serializer model and scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            frm_done = 1'b0;
            if (rst) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) frm_done = 1'b1;
                end
                if (frm_valid && frm_ready) begin
                    accepts++;
                    cd = DONE_DLY;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %h expected no frame", frm_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("frame_data", frm_data, mon_e.frame);
                        chk("frame_ch", {29'd0, cur_ch}, {29'd0, mon_e.ch});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) codes[i] = '0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", frm_valid, 0);
        chk("rst_data", frm_data, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_ch", cur_ch, 0);
        chk("rst_pending", ch_pending, 0);

        // Init frame
        push(32'h0800_0001, 3'd0);
        rst = 1'b0;
        tick();
        chk("init_valid", frm_valid, 1);
        chk("init_word", frm_data, 32'h0800_0001);
        chk("init_busy", busy, 1);
        wait_init("init_wait");
        chk("init_busy_fall", busy, 0);
        chk("init_valid_low", frm_valid, 0);

        // Three channels in one cycle, pointer starts at ch0
        codes[0] = 12'h001;
        codes[5] = 12'h555;
        codes[7] = 12'hFFF;
        push(32'h0300_0100, 3'd0);
        push(32'h0355_5500, 3'd5);
        push(32'h037F_FF00, 3'd7);
        post(8'b1010_0001);
        chk("multi_pending", ch_pending, 8'hA1);
        wait_idle("multi_drain");

        // Last grant was 7: ch0 wraps ahead of ch6
        codes[0] = 12'h0C0;
        codes[6] = 12'h606;
        push(32'h0300_C000, 3'd0);
        push(32'h0366_0600, 3'd6);
        post(8'b0100_0001);
        wait_idle("wrap_drain");

        // Single write latency
        codes[2] = 12'hABC;
        push(32'h032A_BC00, 3'd2);
        post(8'h04);
        chk("lat_pend_set", ch_pending, 8'h04);
        chk("lat_valid_n1", frm_valid, 0);
        tick();
        chk("lat_valid_n2", frm_valid, 1);
        chk("lat_data", frm_data, 32'h032A_BC00);
        chk("lat_cur_ch", cur_ch, 2);
        chk("lat_pend_clr", ch_pending, 0);
        wait_idle("lat_drain");

        // Coalescing while ch1 is in flight
        codes[1] = 12'h0A5;
        push(32'h0310_A500, 3'd1);
        push(32'h0332_2200, 3'd3);
        post(8'h02);
        tick();
        chk("coal_valid", frm_valid, 1);
        codes[3] = 12'h111;
        post(8'h08);
        codes[3] = 12'h222;
        post(8'h08);
        chk("coal_pend3", ch_pending, 8'h08);
        chk("coal_cur_ch", cur_ch, 1);
        wait_idle("coal_drain");

        // Backpressure hold
        frm_ready = 1'b0;
        codes[4] = 12'h3C3;
        push(32'h0343_C300, 3'd4);
        post(8'h10);
        tick();
        chk("hold_valid_first", frm_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", frm_valid, 1);
            chk("hold_data", frm_data, 32'h0343_C300);
        end
        acc_before = accepts;
        frm_ready = 1'b1;
        tick();
        chk("hold_release_valid", frm_valid, 0);
        chk("hold_single_accept", accepts - acc_before, 1);
        wait_idle("hold_drain");

        // Reset during WAIT_DONE with ch1 and ch6 pending
        codes[2] = 12'h123;
        push(32'h0321_2300, 3'd2);
        post(8'h04);
        tick();
        chk("mid_valid", frm_valid, 1);
        tick();
        codes[1] = 12'h777;
        codes[6] = 12'h666;
        post(8'h42);
        chk("mid_pending", ch_pending, 8'h42);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", frm_valid, 0);
        chk("mid_rst_data", frm_data, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cur_ch", cur_ch, 0);
        chk("mid_rst_pending", ch_pending, 0);
        push(32'h0800_0001, 3'd0);
        rst = 1'b0;
        tick();
        chk("reinit_valid", frm_valid, 1);
        chk("reinit_word", frm_data, 32'h0800_0001);
        wait_init("reinit_wait");
        repeat (30) tick();
        chk("reinit_pending", ch_pending, 0);
        chk("reinit_valid_low", frm_valid, 0);
        chk("reinit_busy", busy, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
